// File: rtl/sleep_ctrl.sv
// Core sleep controller: drains the bus, gates the core clock and sequences wake-up.
// Optional macro SLEEP_CTRL_IRQ_SYNC_EN adds a two-flop synchronizer on i_ext_irq.
module sleep_ctrl #(
  parameter int WAKE_DELAY    = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sleep_req,
  input  logic        i_wakeup_req,
  input  logic        i_ext_irq,
  input  logic        i_bus_busy,
  output logic        o_clk_en,
  output logic        o_sleeping,
  output logic        o_sleep_abort,
  output logic [1:0]  o_wake_cause,
  output logic [15:0] o_sleep_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, GATED, WAKE} state_t;

  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_TIMEOUT);
  localparam logic [3:0] WAKE_INIT  = 4'(WAKE_DELAY - 1);

  state_t      state_reg, state_next;
  logic [7:0]  drain_cnt_reg, drain_cnt_next;
  logic [3:0]  wake_cnt_reg, wake_cnt_next;
  logic [1:0]  cause_next;
  logic [15:0] cycles_next;
  logic        abort_next;
  logic        irq;
  logic        wk;
  logic [1:0]  wk_cause;

`ifdef SLEEP_CTRL_IRQ_SYNC_EN
  logic [1:0] irq_sync_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) irq_sync_reg <= 2'b00;
    else       irq_sync_reg <= {irq_sync_reg[0], i_ext_irq};
  end

  assign irq = irq_sync_reg[1];
`else
  assign irq = i_ext_irq;
`endif

  assign wk       = i_wakeup_req | irq;
  assign wk_cause = {irq, i_wakeup_req};

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    wake_cnt_next  = wake_cnt_reg;
    cause_next     = o_wake_cause;
    cycles_next    = o_sleep_cycles;
    abort_next     = 1'b0;
    case (state_reg)
      RUN: begin
        if (i_sleep_req && !wk) begin
          state_next     = DRAIN;
          cause_next     = 2'b00;
          drain_cnt_next = DRAIN_INIT;
        end
      end
      DRAIN: begin
        // A wake event wins over bus idle: abandon the attempt.
        if (wk) begin
          state_next = RUN;
          abort_next = 1'b1;
          cause_next = o_wake_cause | wk_cause;
        end else if (!i_bus_busy) begin
          state_next  = GATED;
          cycles_next = 16'd1;
        end else if (drain_cnt_reg <= 8'd1) begin
          state_next = RUN;
          abort_next = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg - 8'd1;
        end
      end
      GATED: begin
        if (wk) begin
          state_next    = WAKE;
          cause_next    = o_wake_cause | wk_cause;
          wake_cnt_next = WAKE_INIT;
        end else if (o_sleep_cycles != 16'hFFFF) begin
          cycles_next = o_sleep_cycles + 16'd1;
        end
      end
      WAKE: begin
        cause_next = o_wake_cause | wk_cause;
        if (wake_cnt_reg == 4'd0) state_next = RUN;
        else                      wake_cnt_next = wake_cnt_reg - 4'd1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= RUN;
      drain_cnt_reg  <= '0;
      wake_cnt_reg   <= '0;
      o_clk_en       <= 1'b1;
      o_sleeping     <= 1'b0;
      o_sleep_abort  <= 1'b0;
      o_wake_cause   <= 2'b00;
      o_sleep_cycles <= '0;
    end else begin
      state_reg      <= state_next;
      drain_cnt_reg  <= drain_cnt_next;
      wake_cnt_reg   <= wake_cnt_next;
      o_clk_en       <= !(state_next == GATED || state_next == WAKE);
      o_sleeping     <= (state_next == GATED || state_next == WAKE);
      o_sleep_abort  <= abort_next;
      o_wake_cause   <= cause_next;
      o_sleep_cycles <= cycles_next;
    end
  end

endmodule

// File: tb/tb_sleep_ctrl.sv
// Directed vector bench for sleep_ctrl (default build, direct ext IRQ path).
module tb_sleep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sleep_req, wakeup_req, ext_irq, bus_busy;
  logic        clk_en, sleeping, sleep_abort;
  logic [1:0]  wake_cause;
  logic [15:0] sleep_cycles;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sleep_ctrl #(.WAKE_DELAY(4), .DRAIN_TIMEOUT(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sleep_req    (sleep_req),
    .i_wakeup_req   (wakeup_req),
    .i_ext_irq      (ext_irq),
    .i_bus_busy     (bus_busy),
    .o_clk_en       (clk_en),
    .o_sleeping     (sleeping),
    .o_sleep_abort  (sleep_abort),
    .o_wake_cause   (wake_cause),
    .o_sleep_cycles (sleep_cycles)
  );

  // Inputs driven in one cycle; outputs expected right after that cycle's edge.
  typedef struct {
    logic        sleep, wake, irq, busy;
    logic        clk_en, sleeping, abort;
    logic [1:0]  cause;
    logic [15:0] cycles;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic s, logic w, logic q, logic b,
                              logic ce, logic sl, logic ab,
                              logic [1:0] ca, logic [15:0] cy);
    vec_t v;
    v.sleep = s; v.wake = w; v.irq = q; v.busy = b;
    v.clk_en = ce; v.sleeping = sl; v.abort = ab; v.cause = ca; v.cycles = cy;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic w, logic q, logic b);
    @(negedge clk);
    sleep_req = s; wakeup_req = w; ext_irq = q; bus_busy = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, logic ce, logic sl, logic ab,
                         logic [1:0] ca, logic [15:0] cy);
    chk({tag, " clk_en"},   16'(clk_en),      16'(ce));
    chk({tag, " sleeping"}, 16'(sleeping),    16'(sl));
    chk({tag, " abort"},    16'(sleep_abort), 16'(ab));
    chk({tag, " cause"},    16'(wake_cause),  16'(ca));
    chk({tag, " cycles"},   sleep_cycles,     cy);
  endtask

  initial begin
    // Basic sleep/wake by timer: GATED for 9 cycles, WAKE for 4.
    add(0,0,0,0, 1,0,0, 2'b00, 16'd0);
    add(1,0,0,0, 1,0,0, 2'b00, 16'd0);   // DRAIN
    add(0,0,0,0, 0,1,0, 2'b00, 16'd1);   // GATED
    for (int k = 2; k <= 9; k++) add(0,0,0,0, 0,1,0, 2'b00, 16'(k));
    add(0,1,0,0, 0,1,0, 2'b01, 16'd9);   // WAKE
    for (int k = 0; k < 3; k++) add(0,0,0,0, 0,1,0, 2'b01, 16'd9);
    add(0,0,0,0, 1,0,0, 2'b01, 16'd9);   // RUN
    // Sleep together with wake in RUN is ignored.
    add(1,1,0,0, 1,0,0, 2'b01, 16'd9);
    add(0,0,0,0, 1,0,0, 2'b01, 16'd9);
    // Bus stays busy: 16 DRAIN cycles, then abort.
    add(1,0,0,1, 1,0,0, 2'b00, 16'd9);
    for (int k = 0; k < 15; k++) add(0,0,0,1, 1,0,0, 2'b00, 16'd9);
    add(0,0,0,1, 1,0,1, 2'b00, 16'd9);
    add(0,0,0,0, 1,0,0, 2'b00, 16'd9);
    // External IRQ during DRAIN aborts and records cause.
    add(1,0,0,1, 1,0,0, 2'b00, 16'd9);
    add(0,0,0,1, 1,0,0, 2'b00, 16'd9);
    add(0,0,0,1, 1,0,0, 2'b00, 16'd9);
    add(0,0,1,1, 1,0,1, 2'b10, 16'd9);
    add(0,0,0,0, 1,0,0, 2'b10, 16'd9);
    // Simultaneous timer and IRQ wake from GATED.
    add(1,0,0,0, 1,0,0, 2'b00, 16'd9);
    add(0,0,0,0, 0,1,0, 2'b00, 16'd1);
    add(0,1,1,0, 0,1,0, 2'b11, 16'd1);
    for (int k = 0; k < 3; k++) add(0,0,0,0, 0,1,0, 2'b11, 16'd1);
    add(0,0,0,0, 1,0,0, 2'b11, 16'd1);
    // Sleep ignored in GATED/WAKE; IRQ during WAKE ORs in without restarting.
    add(1,0,0,0, 1,0,0, 2'b00, 16'd1);
    add(0,0,0,0, 0,1,0, 2'b00, 16'd1);
    add(1,0,0,0, 0,1,0, 2'b00, 16'd2);
    add(0,1,0,0, 0,1,0, 2'b01, 16'd2);
    add(0,0,1,0, 0,1,0, 2'b11, 16'd2);
    add(1,0,0,0, 0,1,0, 2'b11, 16'd2);
    add(0,0,0,0, 0,1,0, 2'b11, 16'd2);
    add(0,0,0,0, 1,0,0, 2'b11, 16'd2);

    rst = 1'b1; sleep_req = 0; wakeup_req = 0; ext_irq = 0; bus_busy = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1, 0, 0, 2'b00, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sleep, vecs[i].wake, vecs[i].irq, vecs[i].busy);
      chk_all($sformatf("vec%0d", i), vecs[i].clk_en, vecs[i].sleeping,
              vecs[i].abort, vecs[i].cause, vecs[i].cycles);
    end

    // Long GATED period: counter saturates at 16'hFFFF.
    drive(1,0,0,0);
    drive(0,0,0,0);
    chk("sat entry", sleep_cycles, 16'd1);
    repeat (65533) drive(0,0,0,0);
    chk("sat pre", sleep_cycles, 16'hFFFE);
    drive(0,0,0,0);
    chk("sat reach", sleep_cycles, 16'hFFFF);
    repeat (4465) drive(0,0,0,0);
    chk("sat hold", sleep_cycles, 16'hFFFF);
    chk("sat gated", 16'(clk_en), 16'd0);
    drive(0,1,0,0);
    chk_all("in wake", 0, 1, 0, 2'b01, 16'hFFFF);

    // Reset asserted while in WAKE.
    @(negedge clk);
    rst = 1'b1; wakeup_req = 0;
    @(posedge clk);
    #1;
    chk_all("wake reset", 1, 0, 0, 2'b00, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0,0,0,0);
    chk_all("post reset", 1, 0, 0, 2'b00, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
